// File: rtl/m_ucode_loader.sv
// rtl/m_ucode_loader.sv - microcode write-side loader: byte stream to 48-bit EBR words
//
// Takes a byte stream over a valid/ready handshake. Every six bytes, taken
// little-endian, form one 48-bit microcode word, which is written to the ucode
// EBR write port at consecutive 8-bit addresses. When CHECKSUM is set, one more
// byte closes the load: a two's-complement checksum over all data bytes.
//
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   start, base, count begin a load at address base for count (0..256) words;
//                      sampled only while idle
//   in_valid, in_data  byte source
//   in_ready           loader takes a byte this cycle (transfer = in_valid & in_ready)
//   we, waddr, wdata   microcode write port, one we pulse per word
//   busy               load in flight; holds the core
//   done               one-cycle pulse at the end of a load
//   err                sticky checksum mismatch, cleared by the next accepted start
module m_ucode_loader #(
   parameter int unsigned CHECKSUM = 1
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        start,
   input  logic [7:0]  base,
   input  logic [8:0]  count,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        we,
   output logic [7:0]  waddr,
   output logic [47:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BYTES = 3'd1,
      S_WRITE = 3'd2,
      S_CSUM  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  bytecnt_q, bytecnt_d;
   logic [8:0]  remaining_q, remaining_d;
   logic [7:0]  sum_q, sum_d;
   logic [7:0]  waddr_q, waddr_d;
   logic [47:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic        xfer;

   // Handshake and status outputs are pure decodes of the registered state.
   assign in_ready = (state_q == S_BYTES) || (state_q == S_CSUM);
   assign we       = (state_q == S_WRITE);
   assign done     = (state_q == S_DONE);
   assign busy     = (state_q != S_IDLE);
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign err      = (CHECKSUM != 0) ? err_q : 1'b0;

   assign xfer     = in_valid & in_ready;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= S_IDLE;
         bytecnt_q   <= 3'd0;
         remaining_q <= 9'd0;
         sum_q       <= 8'd0;
         waddr_q     <= 8'd0;
         wdata_q     <= 48'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bytecnt_q   <= bytecnt_d;
         remaining_q <= remaining_d;
         sum_q       <= sum_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bytecnt_d   = bytecnt_q;
      remaining_d = remaining_q;
      sum_d       = sum_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               waddr_d     = base;
               remaining_d = count;
               sum_d       = 8'd0;
               bytecnt_d   = 3'd0;
               err_d       = 1'b0;
               state_d     = (count == 9'd0) ? S_DONE : S_BYTES;
            end
         end

         S_BYTES: begin
            if (xfer) begin
               // Byte n of the word lands in bits [8n+7:8n].
               wdata_d[{bytecnt_q, 3'b000} +: 8] = in_data;
               sum_d = sum_q + in_data;
               if (bytecnt_q == 3'd5) begin
                  bytecnt_d = 3'd0;
                  state_d   = S_WRITE;
               end else begin
                  bytecnt_d = bytecnt_q + 3'd1;
               end
            end
         end

         S_WRITE: begin
            // The address wraps naturally at 8 bits, so a 256-word load
            // ends with waddr back at base.
            waddr_d     = waddr_q + 8'd1;
            remaining_d = remaining_q - 9'd1;
            if (remaining_q != 9'd1) begin
               state_d = S_BYTES;
            end else if (CHECKSUM != 0) begin
               state_d = S_CSUM;
            end else begin
               state_d = S_DONE;
            end
         end

         S_CSUM: begin
            if (xfer) begin
               // A correct checksum brings the running sum to zero.
               err_d   = ((sum_q + in_data) != 8'd0);
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_m_ucode_loader.sv
// tb/tb_m_ucode_loader.sv - directed self-checking bench for m_ucode_loader
module tb_m_ucode_loader;

   logic        clk      = 1'b0;
   logic        nrst     = 1'b0;
   logic        start    = 1'b0;
   logic [7:0]  base     = 8'h00;
   logic [8:0]  count    = 9'd0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data  = 8'h00;
   logic        in_ready;
   logic        we;
   logic [7:0]  waddr;
   logic [47:0] wdata;
   logic        busy;
   logic        done;
   logic        err;

   m_ucode_loader #(.CHECKSUM(1)) dut (
      .clk      (clk),
      .nrst     (nrst),
      .start    (start),
      .base     (base),
      .count    (count),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int compares = 0;
   int fails    = 0;

   logic [7:0]  stream[$];
   logic [7:0]  wa_log[$];
   logic [47:0] wd_log[$];
   int          done_idx;
   int          n_done;
   logic        err_at_done;
   logic        err_after_start;
   logic        saw_ready;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compares++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Data bytes for n words plus a trailing checksum (valid unless bad).
   task automatic make_stream(input int n, input logic [7:0] seed, input bit bad);
      logic [7:0] s;
      logic [7:0] b;
      stream.delete();
      s = 8'h00;
      for (int i = 0; i < 6 * n; i++) begin
         b = seed + 8'(i * 37);
         stream.push_back(b);
         s = s + b;
      end
      stream.push_back(bad ? 8'h00 : 8'(8'h00 - s));
   endtask

   // Drives one load and logs every write and the done pulse.
   task automatic run_load(input logic [7:0] b, input logic [8:0] n, input bit stall,
                           input int restart_at, input int budget);
      int          ptr;
      bit          xfer;
      logic [47:0] wd_prev;
      ptr = 0;
      wa_log.delete();
      wd_log.delete();
      done_idx        = -1;
      n_done          = 0;
      saw_ready       = 1'b0;
      err_at_done     = 1'bx;
      err_after_start = 1'bx;
      start    = 1'b1;
      base     = b;
      count    = n;
      in_valid = 1'b0;
      for (int idx = 0; idx < budget && done_idx < 0; idx++) begin
         if (idx > 0) begin
            start = (idx == restart_at);
            base  = 8'h80;
            count = 9'd3;
            in_valid = (ptr < stream.size()) &&
                       (stall ? 1'($urandom_range(0, 1)) : 1'b1);
         end
         in_data = (ptr < stream.size()) ? stream[ptr] : 8'h00;
         xfer    = in_valid & in_ready;
         wd_prev = wdata;
         tick();
         if (xfer) ptr++;
         else chk("wdata_hold", wdata, wd_prev);
         if (idx == 0) err_after_start = err;
         if (in_ready) saw_ready = 1'b1;
         if (we) begin
            wa_log.push_back(waddr);
            wd_log.push_back(wdata);
         end
         if (done) begin
            n_done++;
            done_idx    = idx + 1;
            err_at_done = err;
         end
      end
      start    = 1'b0;
      in_valid = 1'b0;
      chk("done_seen", done_idx > 0, 1'b1);
   endtask

   task automatic check_words(input logic [7:0] b, input int n);
      logic [47:0] w;
      chk("n_we", wa_log.size(), n);
      for (int i = 0; i < n && i < wa_log.size(); i++) begin
         w = '0;
         for (int k = 0; k < 6; k++) w[8*k +: 8] = stream[6*i + k];
         chk("waddr", wa_log[i], 8'(b + 8'(i)));
         chk("wdata", wd_log[i], w);
      end
   endtask

   task automatic s1_stream();
      stream.delete();
      for (int i = 1; i <= 6; i++) stream.push_back(8'(i));
      stream.push_back(8'hEB);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_we", we, 1'b0);
      chk("rst_waddr", waddr, 8'h00);
      chk("rst_wdata", wdata, 48'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      @(posedge clk);
      #1;
      nrst = 1'b1;
      tick();

      // 1: single word, good checksum, 10 cycles start..done inclusive
      s1_stream();
      run_load(8'h10, 9'd1, 1'b0, -1, 40);
      check_words(8'h10, 1);
      chk("s1_wdata_const", wd_log.size() > 0 ? wd_log[0] : 48'hx, 48'h060504030201);
      chk("s1_cycles", done_idx + 1, 10);
      chk("s1_err", err_at_done, 1'b0);
      chk("s1_ndone", n_done, 1);
      tick();
      chk("s1_idle", busy, 1'b0);

      // 2: address wrap
      make_stream(2, 8'h5A, 1'b0);
      run_load(8'hFF, 9'd2, 1'b0, -1, 60);
      check_words(8'hFF, 2);
      chk("s2_final_waddr", waddr, 8'h01);
      chk("s2_err", err_at_done, 1'b0);
      tick();

      // 3: bad checksum, word still written, err sticky
      s1_stream();
      stream[6] = 8'h00;
      run_load(8'h10, 9'd1, 1'b0, -1, 40);
      check_words(8'h10, 1);
      chk("s3_err_done", err_at_done, 1'b1);
      tick();
      tick();
      chk("s3_err_sticky", err, 1'b1);

      // 6a: zero count, also clears err on start
      stream.delete();
      run_load(8'h20, 9'd0, 1'b0, -1, 10);
      chk("z_err_cleared", err_after_start, 1'b0);
      chk("z_cycles", done_idx + 1, 2);
      chk("z_n_we", wa_log.size(), 0);
      chk("z_no_ready", saw_ready, 1'b0);
      chk("z_err", err_at_done, 1'b0);
      tick();

      // 4: source stalls over 4 words
      make_stream(4, 8'hC3, 1'b0);
      run_load(8'h40, 9'd4, 1'b1, -1, 400);
      check_words(8'h40, 4);
      chk("s4_err", err_at_done, 1'b0);
      chk("s4_final_waddr", waddr, 8'h44);
      tick();

      // 5: reset mid-word
      s1_stream();
      start = 1'b1;
      base  = 8'h10;
      count = 9'd1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = stream[i];
         tick();
      end
      chk("s5_busy_pre", busy, 1'b1);
      #2;
      nrst = 1'b0;
      #1;
      chk("s5_in_ready", in_ready, 1'b0);
      chk("s5_we", we, 1'b0);
      chk("s5_waddr", waddr, 8'h00);
      chk("s5_wdata", wdata, 48'h0);
      chk("s5_busy", busy, 1'b0);
      chk("s5_done", done, 1'b0);
      chk("s5_err", err, 1'b0);
      in_valid = 1'b0;
      tick();
      chk("s5_we_held", we, 1'b0);
      nrst = 1'b1;
      tick();
      chk("s5_idle_after", busy, 1'b0);
      s1_stream();
      run_load(8'h10, 9'd1, 1'b0, -1, 40);
      check_words(8'h10, 1);
      chk("s5_reload_cycles", done_idx + 1, 10);
      chk("s5_reload_err", err_at_done, 1'b0);
      tick();

      // 6b: start while busy is ignored
      s1_stream();
      run_load(8'h10, 9'd1, 1'b0, 3, 40);
      check_words(8'h10, 1);
      chk("s6_ndone", n_done, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("s6_stays_idle", busy, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
